// File: rtl/appliance_pkg.sv
// appliance_pkg: function codes and ice-maker state encoding shared by the zone controller
package appliance_pkg;
  localparam logic [1:0] FUNC_TEMP = 2'b00;
  localparam logic [1:0] FUNC_CAP  = 2'b01;
  localparam logic [1:0] FUNC_ICE  = 2'b10;
  localparam logic [1:0] FUNC_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, FILL, FREEZE, HARVEST} ice_state_t;
endpackage

// File: rtl/zone_thermostat.sv
// zone_thermostat: hysteresis cooling request with a minimum-off lockout timer
module zone_thermostat #(
  parameter int TW = 5,
  parameter int HYST = 2,
  parameter int MIN_OFF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwr,
  input  logic [TW-1:0] set,
  input  logic [TW-1:0] meas,
  output logic          cool
);
  localparam int OW = MIN_OFF > 0 ? $clog2(MIN_OFF + 1) : 1;
  logic [OW-1:0] tmr;
  logic [TW:0] m, s;
  logic hot;
  // one extra bit so set + HYST cannot wrap
  assign m = {1'b0, meas};
  assign s = {1'b0, set};
  assign hot = m > s + (TW+1)'(HYST);
  always_ff @(posedge clk) begin
    if (rst) begin
      cool <= 1'b0;
      tmr <= '0;
    end else if (pwr && cool && m <= s) begin
      cool <= 1'b0;
      tmr <= OW'(MIN_OFF);
    end else begin
      cool <= pwr && (cool || (tmr == '0 && hot));
      tmr <= tmr - OW'(tmr != '0);
    end
  end
endmodule

// File: rtl/appliance_zone_ctrl.sv
// appliance_zone_ctrl: per-zone setpoint/capacity registers, thermostats and timed ice-maker sequencer
module appliance_zone_ctrl
  import appliance_pkg::*;
#(
  parameter int NZONES = 2,
  parameter int TW = 5,
  parameter int CW = 2,
  parameter logic [TW-1:0] DEF_TEMP = 5'd4,
  parameter int HYST = 2,
  parameter int MIN_OFF = 8,
  parameter int ICE_FILL = 4,
  parameter int ICE_FREEZE = 16,
  parameter int ICE_HARVEST = 3,
  localparam int ZW = NZONES > 1 ? $clog2(NZONES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwr,
  input  logic                 wr_en,
  input  logic [1:0]           sel_func,
  input  logic [ZW-1:0]        sel_zone,
  input  logic [TW-1:0]        wdata,
  input  logic [NZONES*TW-1:0] temp_meas,
  input  logic                 bin_full,
  output logic [NZONES*TW-1:0] temp_set,
  output logic [NZONES*CW-1:0] cap_set,
  output logic [NZONES-1:0]    cool,
  output logic                 ice_en,
  output logic [1:0]           ice_state,
  output logic                 water_valve,
  output logic                 harvest,
  output logic                 ice_done,
  output logic                 err
);
  localparam int MAXP = ICE_FILL > ICE_FREEZE ? (ICE_FILL > ICE_HARVEST ? ICE_FILL : ICE_HARVEST)
                                              : (ICE_FREEZE > ICE_HARVEST ? ICE_FREEZE : ICE_HARVEST);
  localparam int PW = MAXP > 1 ? $clog2(MAXP) : 1;
  logic wr_ok, zone_ok, bad;
  assign wr_ok = pwr & wr_en;
  assign zone_ok = 32'(sel_zone) < NZONES;
  assign bad = sel_func == FUNC_RSVD || (!sel_func[1] && !zone_ok);
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_set <= {NZONES{DEF_TEMP}};
      cap_set <= '0;
      ice_en <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= wr_ok & bad;
      if (wr_ok && !bad) begin
        if (sel_func == FUNC_ICE) ice_en <= wdata[0];
        for (int i = 0; i < NZONES; i++)
          if (sel_zone == ZW'(i)) begin
            if (sel_func == FUNC_TEMP) temp_set[i*TW +: TW] <= wdata;
            if (sel_func == FUNC_CAP) cap_set[i*CW +: CW] <= wdata[CW-1:0];
          end
      end
    end
  end
  for (genvar z = 0; z < NZONES; z++) begin : g_zone
    zone_thermostat #(.TW(TW), .HYST(HYST), .MIN_OFF(MIN_OFF)) u_thermo (
      .clk(clk),
      .rst(rst),
      .pwr(pwr),
      .set(temp_set[z*TW +: TW]),
      .meas(temp_meas[z*TW +: TW]),
      .cool(cool[z])
    );
  end
  ice_state_t st;
  logic [PW-1:0] cnt, lim;
  assign ice_state = st;
  assign lim = st == FILL ? PW'(ICE_FILL - 1) : st == FREEZE ? PW'(ICE_FREEZE - 1) : PW'(ICE_HARVEST - 1);
  // bin_full and ice_en only gate the start; a running cycle always completes unless power drops
  always_ff @(posedge clk) begin
    if (rst || !pwr) begin
      st <= IDLE;
      cnt <= '0;
      water_valve <= 1'b0;
      harvest <= 1'b0;
      ice_done <= 1'b0;
    end else if (st == IDLE) begin
      ice_done <= 1'b0;
      if (ice_en && !bin_full) begin
        st <= FILL;
        water_valve <= 1'b1;
      end
    end else if (cnt != lim) begin
      cnt <= cnt + PW'(1);
      ice_done <= 1'b0;
    end else begin
      cnt <= '0;
      st <= st == FILL ? FREEZE : st == FREEZE ? HARVEST : IDLE;
      water_valve <= 1'b0;
      harvest <= st == FREEZE;
      ice_done <= st == HARVEST;
    end
  end
endmodule

// File: tb/tb_appliance_zone_ctrl.sv
// tb_appliance_zone_ctrl: directed stimulus checked every cycle against a cycle-count based behavioural model
module tb_appliance_zone_ctrl;
  localparam int N = 3, TW = 5, CW = 2, HYST = 2, MIN_OFF = 8;
  localparam int F = 4, Z = 16, H = 3, T = F + Z + H;
  logic clk = 0, rst = 1, pwr = 0, wr_en = 0, bin_full = 0;
  logic [1:0] sel_func = 0;
  logic [1:0] sel_zone = 0;
  logic [TW-1:0] wdata = 0;
  logic [N*TW-1:0] temp_meas = {N{5'd4}};
  logic [N*TW-1:0] temp_set;
  logic [N*CW-1:0] cap_set;
  logic [N-1:0] cool;
  logic ice_en, water_valve, harvest, ice_done, err;
  logic [1:0] ice_state;
  int vecs = 0, miss = 0, cyc = 0;
  int m_set[N], m_cap[N], m_cool[N], m_off[N];
  int m_ice_en, m_active, m_start, m_done, m_err;
  int nf, nz, nh, nd, zeros;

  appliance_zone_ctrl #(.NZONES(N), .TW(TW), .CW(CW), .DEF_TEMP(5'd4), .HYST(HYST), .MIN_OFF(MIN_OFF),
    .ICE_FILL(F), .ICE_FREEZE(Z), .ICE_HARVEST(H)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .wr_en(wr_en), .sel_func(sel_func), .sel_zone(sel_zone),
    .wdata(wdata), .temp_meas(temp_meas), .bin_full(bin_full), .temp_set(temp_set), .cap_set(cap_set),
    .cool(cool), .ice_en(ice_en), .ice_state(ice_state), .water_valve(water_valve), .harvest(harvest),
    .ice_done(ice_done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int m_state();
    int k;
    if (m_active == 0) return 0;
    k = cyc - m_start;
    return k < F ? 1 : k < F + Z ? 2 : 3;
  endfunction

  task automatic tick();
    int ts, cs, cl, meas;
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_set[i] = 4; m_cap[i] = 0; m_cool[i] = 0; m_off[i] = -100;
      end
      m_ice_en = 0; m_active = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      for (int i = 0; i < N; i++) begin
        meas = int'(temp_meas[i*TW +: TW]);
        if (!pwr) m_cool[i] = 0;
        else if (m_cool[i] != 0 && meas <= m_set[i]) begin m_cool[i] = 0; m_off[i] = cyc; end
        else if (m_cool[i] == 0 && cyc - m_off[i] > MIN_OFF && meas > m_set[i] + HYST) m_cool[i] = 1;
      end
      if (!pwr) m_active = 0;
      else if (m_active != 0) begin
        if (cyc - m_start == T) begin m_active = 0; m_done = 1; end
      end else if (m_ice_en != 0 && !bin_full) begin m_active = 1; m_start = cyc; end
      if (pwr && wr_en) begin
        if (sel_func == 3 || (sel_func < 2 && int'(sel_zone) >= N)) m_err = 1;
        else if (sel_func == 0) m_set[sel_zone] = int'(wdata);
        else if (sel_func == 1) m_cap[sel_zone] = int'(wdata) % 4;
        else m_ice_en = int'(wdata[0]);
      end
    end
    @(posedge clk);
    #1;
    ts = 0; cs = 0; cl = 0;
    for (int i = 0; i < N; i++) begin
      ts += m_set[i] << (i * TW);
      cs += m_cap[i] << (i * CW);
      cl += m_cool[i] << i;
    end
    chk("temp_set", int'(temp_set), ts);
    chk("cap_set", int'(cap_set), cs);
    chk("cool", int'(cool), cl);
    chk("ice_en", int'(ice_en), m_ice_en);
    chk("ice_state", int'(ice_state), m_state());
    chk("water_valve", int'(water_valve), int'(m_state() == 1));
    chk("harvest", int'(harvest), int'(m_state() == 3));
    chk("ice_done", int'(ice_done), m_done);
    chk("err", int'(err), m_err);
  endtask

  task automatic wr(input int f, input int zn, input int d);
    sel_func = 2'(f); sel_zone = 2'(zn); wdata = TW'(d); wr_en = 1;
    tick();
    wr_en = 0;
  endtask

  task automatic set_meas(input int zn, input int v);
    temp_meas[zn*TW +: TW] = TW'(v);
  endtask

  initial begin
    tick(); tick();
    rst = 0; pwr = 1;
    tick();
    wr(0, 1, 9);
    chk("lit_set1", int'(temp_set[9:5]), 9);
    chk("lit_set0", int'(temp_set[4:0]), 4);
    chk("lit_err0", int'(err), 0);
    wr(1, 0, 3); wr(3, 0, 7);
    chk("lit_err_rsvd", int'(err), 1);
    tick();
    chk("lit_err_pulse", int'(err), 0);
    wr(0, 3, 20);
    chk("lit_err_zone", int'(err), 1);
    chk("lit_set_kept", int'(temp_set), (4 << 10) | (9 << 5) | 4);
    wr(1, 2, 5'b10111);
    chk("lit_cap_trunc", int'(cap_set[5:4]), 3);
    pwr = 0;
    wr(0, 0, 1);
    chk("lit_nopwr_err", int'(err), 0);
    pwr = 1;
    tick();
    chk("lit_nopwr_set", int'(temp_set[4:0]), 4);
    set_meas(0, 7); tick();
    chk("lit_cool_on", int'(cool[0]), 1);
    set_meas(0, 4); tick();
    chk("lit_cool_off", int'(cool[0]), 0);
    set_meas(0, 9); zeros = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!cool[0]) zeros++;
    end
    chk("lit_min_off", zeros, 8);
    set_meas(1, 12);
    wr(0, 1, 10);
    chk("lit_old_set", int'(cool[1]), 1);
    wr(0, 2, 30);
    set_meas(2, 31); tick();
    chk("lit_hyst_edge", int'(cool[2]), 0);
    wr(0, 2, 28);
    tick();
    chk("lit_no_wrap", int'(cool[2]), 1);
    wr(2, 0, 1);
    nf = 0; nz = 0; nh = 0; nd = 0;
    for (int i = 0; i < 40 && nd == 0; i++) begin
      tick();
      if (ice_state == 2'd1) nf++;
      if (ice_state == 2'd2) nz++;
      if (ice_state == 2'd3) nh++;
      if (ice_done) nd++;
    end
    chk("lit_fill_len", nf, 4);
    chk("lit_freeze_len", nz, 16);
    chk("lit_harvest_len", nh, 3);
    chk("lit_done_once", nd, 1);
    tick();
    chk("lit_restart", int'(ice_state), 1);
    for (int i = 0; i < 10 && ice_state != 2'd2; i++) tick();
    wr(2, 0, 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ice_done) nd++;
    end
    chk("lit_finish_done", nd, 1);
    chk("lit_stay_idle", int'(ice_state), 0);
    bin_full = 1;
    wr(2, 0, 1);
    repeat (5) tick();
    chk("lit_bin_full", int'(ice_state), 0);
    bin_full = 0;
    tick();
    chk("lit_bin_clear", int'(ice_state), 1);
    tick();
    pwr = 0;
    tick();
    chk("lit_pwr_state", int'(ice_state), 0);
    chk("lit_pwr_valve", int'(water_valve), 0);
    chk("lit_pwr_cool", int'(cool), 0);
    chk("lit_pwr_done", int'(ice_done), 0);
    chk("lit_pwr_set", int'(temp_set[9:5]), 10);
    pwr = 1;
    repeat (9) tick();
    chk("lit_pre_rst", int'(ice_state), 2);
    rst = 1;
    tick();
    chk("lit_rst_state", int'(ice_state), 0);
    chk("lit_rst_done", int'(ice_done), 0);
    rst = 0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/appliance_zone_ctrl.md
# appliance_zone_ctrl

Clocked, parametrised successor of the single-fridge controller. It holds per-zone temperature setpoints and capacity levels for `NZONES` compartments, all writable through one shared write port. It runs a hysteresis thermostat with a minimum-off timer per zone and sequences a timed ice-maker cycle. It sits between the front-panel decoder and the compressor, damper and valve drivers.

## Interface
Parameters:
- `NZONES`, default 2: number of compartments (1–8).
- `TW`, default 5: temperature width, unsigned.
- `CW`, default 2: capacity width.
- `DEF_TEMP`, default 5'd4: setpoint loaded at reset.
- `HYST`, default 2: thermostat hysteresis, in temperature LSBs.
- `MIN_OFF`, default 8: minimum compressor-off cycles.
- `ICE_FILL`, default 4; `ICE_FREEZE`, default 16; `ICE_HARVEST`, default 3: ice-phase durations in cycles, each ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `pwr` in 1: appliance power enable.
- `wr_en` in 1: write strobe.
- `sel_func` in 2: function select. 00 = temperature, 01 = capacity, 10 = ice enable, 11 = reserved.
- `sel_zone` in max(1,$clog2(NZONES)): target zone.
- `wdata` in TW: write value.
- `temp_meas` in NZONES*TW: measured temperature per zone, zone k at [k*TW +: TW].
- `bin_full` in 1: ice bin full sensor.
- `temp_set` out NZONES*TW: setpoints.
- `cap_set` out NZONES*CW: capacity levels.
- `cool` out NZONES: per-zone cooling request.
- `ice_en` out 1: ice maker enabled.
- `ice_state` out 2: ice FSM state.
- `water_valve` out 1: asserted in FILL.
- `harvest` out 1: asserted in HARVEST.
- `ice_done` out 1: one-cycle pulse at end of HARVEST.
- `err` out 1: one-cycle pulse on a rejected write.

## Operation
- Reset values: every `temp_set` zone = `DEF_TEMP`; `cap_set` = 0; `cool` = 0; all off-timers = 0 (expired); `ice_en` = 0; `ice_state` = IDLE; `water_valve`, `harvest`, `ice_done`, `err` = 0.
- Write: accepted when `pwr & wr_en`. Registered; the new value is visible the cycle after the strobe.
  - Function 00: `temp_set[zone] <= wdata`.
  - Function 01: `cap_set[zone] <= wdata[CW-1:0]`. Upper bits are ignored.
  - Function 10: `ice_en <= wdata[0]`. `sel_zone` is ignored.
- Rejected write: function 11, or `sel_zone ≥ NZONES` on function 00/01. No register changes and `err` pulses for one cycle. With `pwr` low, a write is silently ignored and `err` stays 0.
- `pwr` low: all `cool` bits = 0 on the next edge. The ice FSM goes to IDLE and its counter clears. Setpoints, capacities and `ice_en` are retained.
- Thermostat, per zone, with comparisons done unsigned at TW+1 bits so there is no wrap:
  - Turn on: `cool` 0→1 when `pwr`, the off-timer is 0, and `temp_meas > temp_set + HYST`.
  - Turn off: `cool` 1→0 when `temp_meas ≤ temp_set`. This loads the off-timer with `MIN_OFF`. The timer decrements each cycle while nonzero.
  - Setpoint change: a new setpoint takes effect on the compare in the following cycle. It does not restart the off-timer.
- Ice FSM states: IDLE=00, FILL=01, FREEZE=10, HARVEST=11.
  - IDLE→FILL when `pwr & ice_en & ~bin_full`.
  - FILL lasts `ICE_FILL` cycles, then goes to FREEZE. FREEZE lasts `ICE_FREEZE` cycles, then goes to HARVEST. HARVEST lasts `ICE_HARVEST` cycles, then goes to IDLE with `ice_done` pulsing in the same cycle as that transition.
  - `ice_en` deasserted mid-cycle: the current cycle completes and no new cycle starts.
  - `bin_full` is sampled only in IDLE.
  - `pwr` low aborts from any state without pulsing `ice_done`.

## Timing
- All outputs are registered. Writes have 1-cycle latency. `cool` responds 1 cycle after the qualifying `temp_meas`.
- Ice cycle from leaving IDLE back to IDLE takes `ICE_FILL+ICE_FREEZE+ICE_HARVEST` cycles. With `ice_en` held and the bin not full, the earliest restart is FILL entered 1 cycle after `ice_done`.
- `rst` wins over every other input in the same cycle.
- Reset asserted mid-ice-cycle returns the FSM to IDLE with no `ice_done`.
- Simultaneous write and thermostat event in the same cycle: the thermostat uses the old setpoint.

## Structure
- Package `appliance_pkg`:
  - function-code constants `FUNC_TEMP`, `FUNC_CAP`, `FUNC_ICE`, `FUNC_RSVD`;
  - enum `ice_state_t` {IDLE, FILL, FREEZE, HARVEST}.
- Sub-module `zone_thermostat`, instantiated `NZONES` times by generate. It has parameters `TW`, `HYST`, `MIN_OFF` and ports `clk`, `rst`, `pwr`, `set`, `meas`, `cool`.
- The ice FSM and its phase counter live in the top level, with the counter sized for the largest phase.

## Test plan
- Reset, then write zone 1, function 00, `wdata` = 9 → `temp_set[1]` = 9 the next cycle, zone 0 stays 4, `err` = 0.
- Write function 11, or `sel_zone` = 2 with NZONES = 2 → `err` high for exactly 1 cycle, all registers unchanged.
- Zone 0 with set = 4: `temp_meas` = 7 → `cool` = 1. Then meas = 4 → `cool` = 0. Then meas = 9 immediately → `cool` stays 0 for 8 cycles, then goes to 1.
- Ice enable written, `bin_full` = 0 → states 01 for 4 cycles, 10 for 16 cycles, 11 for 3 cycles, `ice_done` pulses once, FILL re-entered 1 cycle later.
- Clear `ice_en` during FREEZE → the cycle completes with `ice_done`, then the FSM stays IDLE. `bin_full` = 1 in IDLE → no start.
- Drop `pwr` during FILL → next cycle `ice_state` = 00, `water_valve` = 0, `cool` = 0, no `ice_done`, setpoints preserved.
